// File: rtl/ptat_a2d_ctrl_pkg.sv
// Shared PTAT A2D definitions: result width and the controller state encoding.
// Also used by the A2D model and the thermal-monitor logic.
package ptat_pkg;
   localparam int A2D_W = 12;

   typedef enum logic [1:0] {IDLE, START, CONV, WAIT} ptat_ctrl_state_t;
endpackage

// File: rtl/ptat_a2d_ctrl_if.sv
// strt/cmplt handshake between the PTAT A2D controller (master) and the A2D (slave).
interface ptat_a2d_ctrl_if;
   import ptat_pkg::*;

   logic             strt;
   logic             cmplt;
   logic [A2D_W-1:0] a2d;

   modport master (output strt, input cmplt, a2d);
   modport slave  (input strt, output cmplt, a2d);
endinterface

// File: rtl/ptat_a2d_ctrl_avg.sv
// Round accumulator: sums samples and publishes the truncated mean on the last one.
module ptat_avg
   import ptat_pkg::*;
#(
   parameter int LOG2_AVG = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             add,
   input  logic [A2D_W-1:0] a2d,
   input  logic             last,
   output logic [A2D_W-1:0] temp,
   output logic             temp_vld
);
   localparam int ACC_W = A2D_W + LOG2_AVG;

   logic [ACC_W-1:0] acc_q, acc_d, sum;
   logic [A2D_W-1:0] temp_q, temp_d;
   logic             vld_q, vld_d;

   assign sum = acc_q + ACC_W'(a2d);

   always_comb begin
      acc_d  = acc_q;
      temp_d = temp_q;
      vld_d  = 1'b0;
      if (clr) begin
         acc_d = '0;
      end else if (add) begin
         if (last) begin
            temp_d = A2D_W'(sum >> LOG2_AVG);
            vld_d  = 1'b1;
            acc_d  = '0;
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         temp_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         temp_q <= temp_d;
         vld_q  <= vld_d;
      end
   end

   assign temp     = temp_q;
   assign temp_vld = vld_q;
endmodule

// File: rtl/ptat_a2d_ctrl.sv
// PTAT A2D initiator: runs averaging rounds of 2^LOG2_AVG conversions separated
// by a ROUND_GAP wait, with a sticky error when the A2D fails to answer.
module ptat_a2d_ctrl
   import ptat_pkg::*;
#(
   parameter int LOG2_AVG  = 2,
   parameter int ROUND_GAP = 256,
   parameter int TIMEOUT   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   clr_err,
   ptat_a2d_ctrl_if.master        a2d_if,
   output logic [A2D_W-1:0]       temp,
   output logic                   temp_vld,
   output logic                   busy,
   output logic                   tmo_err
);
   localparam int CNT_W = LOG2_AVG + 1;
   localparam int GAP_W = $clog2(ROUND_GAP + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   ptat_ctrl_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             strt_q, strt_d, busy_q, busy_d, tmo_err_q, tmo_err_d;
   logic             acc_clr, acc_add, tmo_set, last;

   assign last = (cnt_q == CNT_W'((1 << LOG2_AVG) - 1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = '0;
      tmo_cnt_d = tmo_cnt_q;
      acc_clr   = 1'b0;
      acc_add   = 1'b0;
      tmo_set   = 1'b0;
      unique case (state_q)
         IDLE:  if (en) state_d = START;
         START: begin
            tmo_cnt_d = '0;
            state_d   = CONV;
         end
         CONV: begin
            if (a2d_if.cmplt) begin
               if (last) begin
                  acc_add = 1'b1;
                  cnt_d   = '0;
                  state_d = en ? WAIT : IDLE;
               end else if (!en) begin
                  // round abandoned mid-way: drop the partial sum
                  acc_clr = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  acc_add = 1'b1;
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = START;
               end
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
               tmo_set = 1'b1;
               acc_clr = 1'b1;
               cnt_d   = '0;
               state_d = en ? WAIT : IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         WAIT: begin
            if (!en)                               state_d = IDLE;
            else if (gap_q == GAP_W'(ROUND_GAP - 1)) state_d = START;
            else                                   gap_d   = gap_q + GAP_W'(1);
         end
         default: state_d = IDLE;
      endcase
      strt_d    = (state_d == START);
      busy_d    = (state_d != IDLE);
      tmo_err_d = tmo_set | (tmo_err_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         gap_q     <= '0;
         tmo_cnt_q <= '0;
         strt_q    <= 1'b0;
         busy_q    <= 1'b0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         tmo_cnt_q <= tmo_cnt_d;
         strt_q    <= strt_d;
         busy_q    <= busy_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   ptat_avg #(.LOG2_AVG(LOG2_AVG)) u_avg (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (acc_clr),
      .add      (acc_add),
      .a2d      (a2d_if.a2d),
      .last     (last),
      .temp     (temp),
      .temp_vld (temp_vld)
   );

   assign a2d_if.strt = strt_q;
   assign busy        = busy_q;
   assign tmo_err     = tmo_err_q;
endmodule
